// File: rtl/nmi_request_controller.sv
// NMI front-end: synchronises four IRQ lines, latches pending edges and
// issues them one at a time to the core, tracking the NMI_ACK handshake.
module nmi_request_controller #(
  parameter int unsigned PULSE_LEN = 2,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] irq_in,
  input  logic [3:0] irq_mask,
  input  logic       NMI_ACK,
  output logic       NMI,
  output logic [1:0] NMI_ID,
  output logic [3:0] pending,
  output logic       in_service,
  output logic [7:0] retry_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ASSERT = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_SERV   = 2'd3;

  logic [3:0] s1_q, s2_q, s3_q;
  logic       ack_q;
  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] id_q, id_d;
  logic [3:0] pend_q, pend_d;
  logic [7:0] retry_q, retry_d;
  logic [3:0] rise_w;
  logic [3:0] elig_w;
  logic [3:0] clr_w;

  assign rise_w = s2_q & ~s3_q;
  assign elig_w = pend_q & ~irq_mask;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    retry_d = retry_q;
    clr_w   = 4'b0000;
    unique case (state_q)
      S_IDLE: begin
        if (elig_w != 4'b0000 && ack_q) begin
          for (int i = 3; i >= 0; i--) begin
            if (elig_w[i]) id_d = 2'(i);
          end
          cnt_d   = 8'(PULSE_LEN);
          state_d = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (!ack_q) begin
          clr_w[id_q] = 1'b1;
          state_d     = S_SERV;
        end else if (cnt_q == 8'd1) begin
          cnt_d   = 8'(TIMEOUT);
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_WAIT: begin
        if (!ack_q) begin
          clr_w[id_q] = 1'b1;
          state_d     = S_SERV;
        end else if (cnt_q == 8'd1) begin
          if (retry_q != 8'hff) retry_d = retry_q + 8'd1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SERV: begin
        if (ack_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // a new edge beats an acceptance of the same source
    pend_d = (pend_q & ~clr_w) | rise_w;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= 4'b0000;
      s2_q    <= 4'b0000;
      s3_q    <= 4'b0000;
      ack_q   <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      id_q    <= 2'd0;
      pend_q  <= 4'b0000;
      retry_q <= 8'd0;
    end else begin
      s1_q    <= irq_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      ack_q   <= NMI_ACK;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      retry_q <= retry_d;
    end
  end

  assign NMI         = (state_q == S_ASSERT);
  assign in_service  = (state_q == S_SERV);
  assign NMI_ID      = id_q;
  assign pending     = pend_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_nmi_request_controller.sv
// Bench for nmi_request_controller: directed scenarios plus random
// traffic, every cycle compared against a cycle-count reference model.
module tb_nmi_request_controller;

  localparam int PL  = 2;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] irq_in = 4'b0000;
  logic [3:0] irq_mask = 4'b0000;
  logic       NMI_ACK = 1'b1;
  logic       NMI;
  logic [1:0] NMI_ID;
  logic [3:0] pending;
  logic       in_service;
  logic [7:0] retry_count;

  int n_tests = 0;
  int n_fail  = 0;

  nmi_request_controller #(
    .PULSE_LEN(PL),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .irq_in(irq_in),
    .irq_mask(irq_mask),
    .NMI_ACK(NMI_ACK),
    .NMI(NMI),
    .NMI_ID(NMI_ID),
    .pending(pending),
    .in_service(in_service),
    .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  // reference model: phase plus cycles spent in that phase
  int         m_ph;
  int         m_el;
  int         m_id;
  int         m_retry;
  logic [3:0] m_pend;
  logic [3:0] m_h0, m_h1, m_h2;
  logic       m_ack;
  logic [3:0] m_rise, m_elig, m_clr;

  task automatic model_reset();
    m_ph = 0; m_el = 0; m_id = 0; m_retry = 0;
    m_pend = 0; m_h0 = 0; m_h1 = 0; m_h2 = 0;
    m_ack = 1'b1;
  endtask

  task automatic model_step();
    m_rise = m_h1 & ~m_h2;
    m_clr  = 4'b0000;
    case (m_ph)
      0: begin
        m_elig = m_pend & ~irq_mask;
        if (m_elig != 0 && m_ack) begin
          for (int i = 0; i < 4; i++)
            if (m_elig[i]) begin m_id = i; break; end
          m_ph = 1; m_el = 1;
        end
      end
      1: begin
        if (!m_ack) begin m_clr[m_id] = 1'b1; m_ph = 3; end
        else if (m_el == PL) begin m_ph = 2; m_el = 1; end
        else m_el++;
      end
      2: begin
        if (!m_ack) begin m_clr[m_id] = 1'b1; m_ph = 3; end
        else if (m_el == TMO) begin
          if (m_retry < 255) m_retry++;
          m_ph = 0;
        end else m_el++;
      end
      default: if (m_ack) m_ph = 0;
    endcase
    m_pend = (m_pend & ~m_clr) | m_rise;
    m_h2 = m_h1; m_h1 = m_h0; m_h0 = irq_in;
    m_ack = NMI_ACK;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("m_nmi", NMI, m_ph == 1);
        chk("m_id", NMI_ID, m_id);
        chk("m_pend", pending, m_pend);
        chk("m_insvc", in_service, m_ph == 3);
        chk("m_retry", retry_count, m_retry);
      end
    end
  end

  task automatic pulse_irq(input logic [3:0] v);
    irq_in = v;
    repeat (3) @(negedge clk);
    irq_in = 4'b0000;
  endtask

  task automatic wait_nmi(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (NMI) break;
      @(negedge clk);
    end
    chk("wait_nmi", NMI, 1'b1);
  endtask

  task automatic ack_cycle(input int n);
    NMI_ACK = 1'b0;
    repeat (n) @(negedge clk);
    NMI_ACK = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    repeat (6) @(negedge clk);
  endtask

  int cnt;
  int gap;
  logic prev;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_nmi", NMI, 1'b0);
    chk("rst_id", NMI_ID, 2'd0);
    chk("rst_pend", pending, 4'b0000);
    chk("rst_insvc", in_service, 1'b0);
    chk("rst_retry", retry_count, 8'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // single request from source 2
    pulse_irq(4'b0100);
    wait_nmi(10);
    chk("single_id", NMI_ID, 2'd2);
    chk("single_pend", pending, 4'b0100);
    cnt = 0;
    for (int i = 0; i < 10 && NMI; i++) begin
      cnt++;
      @(negedge clk);
    end
    chk("pulse_len", cnt, PL);
    NMI_ACK = 1'b0;
    repeat (10) @(negedge clk);
    chk("single_insvc", in_service, 1'b1);
    chk("single_clr", pending, 4'b0000);
    NMI_ACK = 1'b1;
    repeat (3) @(negedge clk);
    chk("single_idle", in_service, 1'b0);
    wait_idle();

    // priority: 1 before 3
    pulse_irq(4'b1010);
    wait_nmi(10);
    chk("prio_first", NMI_ID, 2'd1);
    ack_cycle(5);
    wait_nmi(6);
    chk("prio_second", NMI_ID, 2'd3);
    ack_cycle(5);
    wait_idle();

    // mask holds source 0 back
    irq_mask = 4'b0001;
    pulse_irq(4'b0001);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (NMI) cnt++;
    end
    chk("mask_no_nmi", cnt, 0);
    chk("mask_pend", pending, 4'b0001);
    irq_mask = 4'b0000;
    wait_nmi(5);
    chk("mask_id", NMI_ID, 2'd0);
    ack_cycle(4);
    wait_idle();

    // timeouts with ACK held high
    pulse_irq(4'b0100);
    wait_nmi(10);
    for (int k = 0; k < 2; k++) begin
      prev = 1'b1;
      gap = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        gap++;
        if (NMI && !prev) break;
        prev = NMI;
      end
      chk("retry_period", gap, PL + TMO + 1);
    end
    chk("retry_two", retry_count, 8'd2);
    chk("retry_id", NMI_ID, 2'd2);
    while (NMI) @(negedge clk);
    pulse_irq(4'b0001);
    wait_nmi(12);
    chk("gap_prio_id", NMI_ID, 2'd0);
    ack_cycle(4);
    wait_nmi(6);
    chk("gap_src2_id", NMI_ID, 2'd2);
    ack_cycle(4);
    wait_idle();

    // re-request of the source in service
    pulse_irq(4'b0100);
    wait_nmi(10);
    NMI_ACK = 1'b0;
    repeat (3) @(negedge clk);
    pulse_irq(4'b0100);
    repeat (3) @(negedge clk);
    chk("rereq_insvc", in_service, 1'b1);
    chk("rereq_pend", pending, 4'b0100);
    NMI_ACK = 1'b1;
    wait_nmi(6);
    chk("rereq_id", NMI_ID, 2'd2);
    ack_cycle(4);
    wait_idle();

    // asynchronous reset while NMI is high
    pulse_irq(4'b0010);
    wait_nmi(10);
    #2 reset = 1'b1;
    #1;
    chk("arst_nmi", NMI, 1'b0);
    chk("arst_pend", pending, 4'b0000);
    chk("arst_insvc", in_service, 1'b0);
    chk("arst_retry", retry_count, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (NMI) cnt++;
    end
    chk("arst_quiet", cnt, 0);

    // random traffic against the model
    cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 15) == 0) irq_in[b] = ~irq_in[b];
      if ($urandom_range(0, 49) == 0)
        irq_mask = 4'($urandom_range(0, 15));
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) NMI_ACK = 1'b1;
      end else if (NMI && $urandom_range(0, 3) != 0) begin
        NMI_ACK = 1'b0;
        cnt = $urandom_range(1, 8);
      end else if ($urandom_range(0, 63) == 0) begin
        NMI_ACK = 1'b0;
        cnt = 2;
      end
      if ($urandom_range(0, 799) == 0) begin
        #2 reset = 1'b1;
        #1;
        chk("rnd_arst_nmi", NMI, 1'b0);
        chk("rnd_arst_pend", pending, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
